// File: rtl/core_mem_pkg.sv
// Shared types for the core memory arbiter: FSM states, full-word byte select,
// and the registered bus request bundle.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } mem_state_t;

    localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

    // Widest address the bus bundle can carry; narrower ports are zero-extended.
    localparam int MEM_ADDR_MAX = 64;

    typedef struct packed {
        logic                    we;
        logic [MEM_ADDR_MAX-1:0] addr;
        logic [31:0]             wdata;
        logic [3:0]              sel;
    } mem_bus_req_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-outstanding memory bus.
// Data has priority; a starvation counter hands fetch the grant after a run of data wins.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_inst_req,
    input  logic [ADDR_WIDTH-1:0] i_inst_addr,
    output logic                  o_inst_ack,
    output logic                  o_inst_err,
    output logic [31:0]           o_inst_rdata,
    input  logic                  i_data_req,
    input  logic                  i_data_we,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [31:0]           i_data_wdata,
    input  logic [3:0]            i_data_sel,
    output logic                  o_data_ack,
    output logic                  o_data_err,
    output logic [31:0]           o_data_rdata,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [31:0]           o_bus_wdata,
    output logic [3:0]            o_bus_sel,
    input  logic                  i_bus_ack,
    input  logic                  i_bus_err,
    input  logic [31:0]           i_bus_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    mem_state_t       state_q, state_d;
    mem_bus_req_t     bus_q, bus_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inst_active;
    logic             data_active;

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_data_req && !(i_inst_req && cnt_q == CNT_MAX)) begin
                    state_d     = DATA;
                    req_d       = 1'b1;
                    bus_d.we    = i_data_we;
                    bus_d.addr  = MEM_ADDR_MAX'(i_data_addr);
                    bus_d.wdata = i_data_wdata;
                    bus_d.sel   = i_data_sel;
                    // Count only data wins that actually made fetch wait.
                    if (!i_inst_req) begin
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (i_inst_req) begin
                    state_d     = INST;
                    req_d       = 1'b1;
                    bus_d.we    = 1'b0;
                    bus_d.addr  = MEM_ADDR_MAX'(i_inst_addr);
                    bus_d.wdata = '0;
                    bus_d.sel   = MEM_SEL_WORD;
                    cnt_d       = '0;
                end
            end
            INST, DATA: begin
                if (i_bus_ack || i_bus_err) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            bus_q   <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    // An access being aborted by reset must not report completion.
    assign inst_active = (state_q == INST) && !i_reset;
    assign data_active = (state_q == DATA) && !i_reset;

    assign o_inst_ack   = inst_active && i_bus_ack;
    assign o_inst_err   = inst_active && i_bus_err;
    assign o_inst_rdata = i_bus_rdata;
    assign o_data_ack   = data_active && i_bus_ack;
    assign o_data_err   = data_active && i_bus_err;
    assign o_data_rdata = i_bus_rdata;

    assign o_bus_req   = req_q;
    assign o_bus_we    = bus_q.we;
    assign o_bus_addr  = ADDR_WIDTH'(bus_q.addr);
    assign o_bus_wdata = bus_q.wdata;
    assign o_bus_sel   = bus_q.sel;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus a randomized
// run against a grant-order model built from the arbitration rules.
module tb_core_mem_arbiter;

    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_ack, inst_err;
    logic [31:0]   inst_rdata;
    logic          data_req, data_we;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic [3:0]    data_sel;
    logic          data_ack, data_err;
    logic [31:0]   data_rdata;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic [3:0]    bus_sel;
    logic          bus_ack, bus_err;
    logic [31:0]   bus_rdata;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_inst_req(inst_req), .i_inst_addr(inst_addr),
        .o_inst_ack(inst_ack), .o_inst_err(inst_err), .o_inst_rdata(inst_rdata),
        .i_data_req(data_req), .i_data_we(data_we), .i_data_addr(data_addr),
        .i_data_wdata(data_wdata), .i_data_sel(data_sel),
        .o_data_ack(data_ack), .o_data_err(data_err), .o_data_rdata(data_rdata),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_sel(bus_sel),
        .i_bus_ack(bus_ack), .i_bus_err(bus_err), .i_bus_rdata(bus_rdata)
    );

    // {req, we, sel, addr, wdata} as seen on the bus
    function automatic logic [69:0] bus_vec();
        return {bus_req, bus_we, bus_sel, bus_addr, bus_wdata};
    endfunction

    function automatic logic [3:0] resp_vec();
        return {inst_ack, inst_err, data_ack, data_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        inst_addr = '0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_sel = '0;
        bus_rdata = '0;
        reset = 1'b1; inst_req = 1'b1; data_req = 1'b1; bus_ack = 1'b0; bus_err = 1'b0;
        step(); step();
        total++;
        if (bus_vec() !== 70'd0) $display("FAIL reset_bus: got %h want 0", bus_vec());
        else passed++;
        bus_ack = 1'b1; #1;
        total++;
        if (resp_vec() !== 4'b0000) $display("FAIL reset_resp: got %b want 0000", resp_vec());
        else passed++;
        bus_ack = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic [69:0] exp;
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h100;
        exp = {1'b1, 1'b0, 4'hF, 32'h100, 32'h0};
        step();
        total++;
        if ({bus_vec(), resp_vec()} !== {exp, 4'b0})
            $display("FAIL fetch_grant: got %h want %h", {bus_vec(), resp_vec()}, {exp, 4'b0});
        else passed++;
        step();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
        total++;
        if ({bus_vec(), resp_vec(), inst_rdata} !== {exp, 4'b1000, 32'hDEADBEEF})
            $display("FAIL fetch_ack: got %h %b %h want %h 1000 deadbeef",
                     bus_vec(), resp_vec(), inst_rdata, exp);
        else passed++;
        inst_req = 1'b0;
        step();
        bus_ack = 1'b0; #1;
        total++;
        if (bus_req !== 1'b0) $display("FAIL fetch_release: got %b want 0", bus_req);
        else passed++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h300;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h204;
        data_sel = 4'b0100; data_wdata = 32'h5A5A5A5A;
        step();
        total++;
        if (bus_vec() !== {1'b1, 1'b1, 4'b0100, 32'h204, 32'h5A5A5A5A})
            $display("FAIL simul_data_grant: got %h want data store 0x204", bus_vec());
        else passed++;
        bus_ack = 1'b1; bus_rdata = 32'h1234; #1;
        total++;
        if (resp_vec() !== 4'b0010) $display("FAIL simul_data_ack: got %b want 0010", resp_vec());
        else passed++;
        data_req = 1'b0;
        step();
        bus_ack = 1'b0; #1;
        total++;
        if (bus_req !== 1'b0) $display("FAIL simul_gap: got %b want 0", bus_req);
        else passed++;
        step();
        total++;
        if (bus_vec() !== {1'b1, 1'b0, 4'hF, 32'h300, 32'h0})
            $display("FAIL simul_inst_grant: got %h want fetch 0x300", bus_vec());
        else passed++;
        bus_ack = 1'b1; #1;
        total++;
        if (resp_vec() !== 4'b1000) $display("FAIL simul_inst_ack: got %b want 1000", resp_vec());
        else passed++;
        inst_req = 1'b0;
        step();
        bus_ack = 1'b0;
    endtask

    // With fetch held waiting and data always requesting, every fifth grant goes to fetch.
    task automatic test_starvation();
        logic [69:0] exp;
        logic        is_inst;
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h400;
        data_req = 1'b1;
        for (int g = 0; g < 2 * (LIMIT + 1); g++) begin
            data_we = 1'($urandom); data_addr = $urandom; data_wdata = $urandom;
            data_sel = 4'($urandom);
            is_inst = (g % (LIMIT + 1)) == LIMIT;
            exp = is_inst ? {1'b1, 1'b0, 4'hF, inst_addr, 32'h0}
                          : {1'b1, data_we, data_sel, data_addr, data_wdata};
            step();
            total++;
            if (bus_vec() !== exp) $display("FAIL starve_grant%0d: got %h want %h", g, bus_vec(), exp);
            else passed++;
            repeat ($urandom_range(0, 2)) step();
            bus_ack = 1'b1; #1;
            total++;
            if (resp_vec() !== (is_inst ? 4'b1000 : 4'b0010))
                $display("FAIL starve_ack%0d: got %b want %b", g, resp_vec(),
                         is_inst ? 4'b1000 : 4'b0010);
            else passed++;
            if (is_inst) inst_addr = inst_addr + 32'h4;
            step();
            bus_ack = 1'b0;
        end
        inst_req = 1'b0; data_req = 1'b0;
        step();
    endtask

    task automatic test_error();
        apply_reset();
        data_req = 1'b1; data_we = 1'b0; data_addr = $urandom; data_sel = 4'hF;
        step();
        bus_err = 1'b1; bus_rdata = $urandom; #1;
        total++;
        if ({resp_vec(), data_rdata} !== {4'b0001, bus_rdata})
            $display("FAIL error_resp: got %b %h want 0001 %h", resp_vec(), data_rdata, bus_rdata);
        else passed++;
        data_req = 1'b0;
        step();
        bus_err = 1'b0; #1;
        total++;
        if (bus_req !== 1'b0) $display("FAIL error_idle: got %b want 0", bus_req);
        else passed++;
        step();
        total++;
        if (bus_req !== 1'b0) $display("FAIL error_stay_idle: got %b want 0", bus_req);
        else passed++;
    endtask

    // Reset lands during the data access that saturated the counter; fetch must not win after it.
    task automatic test_reset_mid();
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h500;
        data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0011;
        for (int g = 0; g < LIMIT - 1; g++) begin
            data_addr = $urandom; data_wdata = $urandom;
            step();
            bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
        end
        data_addr = 32'h7000; data_wdata = 32'hCAFEF00D;
        step();
        step();
        reset = 1'b1; #1;
        total++;
        if (resp_vec() !== 4'b0000) $display("FAIL rst_mid_resp: got %b want 0000", resp_vec());
        else passed++;
        step();
        reset = 1'b0; #1;
        total++;
        if (bus_vec() !== 70'd0) $display("FAIL rst_mid_bus: got %h want 0", bus_vec());
        else passed++;
        data_addr = 32'h7100;
        step();
        total++;
        if (bus_vec() !== {1'b1, 1'b1, 4'b0011, 32'h7100, 32'hCAFEF00D})
            $display("FAIL rst_mid_cnt_cleared: got %h want data grant 0x7100", bus_vec());
        else passed++;
        bus_ack = 1'b1; data_req = 1'b0; inst_req = 1'b0;
        step();
        bus_ack = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        logic [69:0] exp;
        apply_reset();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h880; data_wdata = $urandom;
        data_sel = 4'b1100;
        exp = {1'b1, 1'b0, 4'b1100, 32'h880, data_wdata};
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                inst_req = 1'b1; inst_addr = 32'h600;
            end
            data_addr = $urandom; data_wdata = $urandom;
            #1;
            total++;
            if ({bus_vec(), resp_vec()} !== {exp, 4'b0})
                $display("FAIL wait_hold%0d: got %h want %h", i, {bus_vec(), resp_vec()}, {exp, 4'b0});
            else passed++;
            step();
        end
        bus_ack = 1'b1; bus_rdata = 32'h0BADCAFE; #1;
        total++;
        if ({resp_vec(), data_rdata} !== {4'b0010, 32'h0BADCAFE})
            $display("FAIL wait_ack: got %b %h want 0010 0badcafe", resp_vec(), data_rdata);
        else passed++;
        data_req = 1'b0;
        step();
        bus_ack = 1'b0; #1;
        total++;
        if (bus_req !== 1'b0) $display("FAIL wait_gap: got %b want 0", bus_req);
        else passed++;
        step();
        total++;
        if (bus_vec() !== {1'b1, 1'b0, 4'hF, 32'h600, 32'h0})
            $display("FAIL wait_inst_grant: got %h want fetch 0x600", bus_vec());
        else passed++;
        bus_ack = 1'b1; inst_req = 1'b0;
        step();
        bus_ack = 1'b0;
    endtask

    // Model: fetch wins a contested grant only after LIMIT straight contested data wins.
    task automatic test_random();
        int unsigned data_wins = 0;
        logic        grant_data, use_err;
        logic [69:0] exp;
        logic [3:0]  exp_resp;
        logic [31:0] rd;
        apply_reset();
        for (int r = 0; r < 60; r++) begin
            if (!inst_req && $urandom_range(0, 1) == 1) begin
                inst_req = 1'b1; inst_addr = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) != 0) begin
                data_req = 1'b1; data_we = 1'($urandom); data_addr = $urandom;
                data_wdata = $urandom; data_sel = 4'($urandom);
            end
            if (!inst_req && !data_req) begin
                inst_req = 1'b1; inst_addr = $urandom;
            end
            grant_data = data_req && !(inst_req && data_wins >= LIMIT);
            exp = grant_data ? {1'b1, data_we, data_sel, data_addr, data_wdata}
                             : {1'b1, 1'b0, 4'hF, inst_addr, 32'h0};
            if (grant_data && inst_req) data_wins = (data_wins < LIMIT) ? data_wins + 1 : LIMIT;
            else data_wins = 0;
            step();
            total++;
            if (bus_vec() !== exp) $display("FAIL rand_grant%0d: got %h want %h", r, bus_vec(), exp);
            else passed++;
            repeat ($urandom_range(0, 3)) begin
                step();
                total++;
                if ({bus_vec(), resp_vec()} !== {exp, 4'b0})
                    $display("FAIL rand_hold%0d: got %h want %h", r, {bus_vec(), resp_vec()}, {exp, 4'b0});
                else passed++;
            end
            use_err = $urandom_range(0, 3) == 0;
            rd = $urandom;
            bus_ack = !use_err; bus_err = use_err; bus_rdata = rd; #1;
            exp_resp = grant_data ? {2'b00, !use_err, use_err} : {!use_err, use_err, 2'b00};
            total++;
            if ({resp_vec(), grant_data ? data_rdata : inst_rdata} !== {exp_resp, rd})
                $display("FAIL rand_resp%0d: got %b %h want %b %h", r, resp_vec(),
                         grant_data ? data_rdata : inst_rdata, exp_resp, rd);
            else passed++;
            if (grant_data) data_req = 1'b0;
            else inst_req = 1'b0;
            step();
            bus_ack = 1'b0; bus_err = 1'b0; #1;
            total++;
            if (bus_req !== 1'b0) $display("FAIL rand_gap%0d: got %b want 0", r, bus_req);
            else passed++;
        end
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_error();
        test_reset_mid();
        test_wait_states();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
